// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit multiplexed 7-segment scanner, tear-free updates.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seg7_scan_ctrl #(
  parameter int DIV          = 10,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg7,
  output logic        frame_done
);

  localparam int MAXC = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_END = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYCLES - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [15:0]     display;
  logic [15:0]     pending;
  logic            pend_valid;

  logic            blank_done;
  logic            on_done;
  logic            boundary;
  logic            commit;
  logic [3:0]      nib;
  logic            lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_OFF;
    unique case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Phase-end and frame-boundary detection; commits only at safe points.
  always_comb begin
    blank_done = (state == BLANK) && (cnt == BLK_END);
    on_done    = (state == ON) && (cnt == DIV_END);
    boundary   = on_done && (idx == 2'd3);
    commit     = pend_valid &&
                 ((enable && boundary) || (state == IDLE));
  end

  // Select the nibble of the digit about to be lit.
  always_comb begin
    nib = 4'h0;
    unique case (idx)
      2'd0: nib = display[3:0];
      2'd1: nib = display[7:4];
      2'd2: nib = display[11:8];
      2'd3: nib = display[15:12];
    endcase
  end

  // Leading-zero suppression for digits 3..1; digit0 always shows.
  always_comb begin
    lz = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    unique case (idx)
      2'd3: lz = (display[15:12] == 4'h0);
      2'd2: lz = (display[15:8] == 8'h00);
      2'd1: lz = (display[15:4] == 12'h000);
      2'd0: lz = 1'b0;
    endcase
`endif
  end

  // Double buffer: pending captures loads, display changes only on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      display    <= 16'h0000;
      pending    <= 16'h0000;
      pend_valid <= 1'b0;
    end else begin
      if (commit) begin
        display <= pending;
      end
      if (load) begin
        pending    <= digits;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Scan FSM with registered anode/segment/frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      an         <= AN_OFF;
      seg7       <= SEG_OFF;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      an         <= AN_OFF;
      seg7       <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= BLANK;
          idx   <= 2'd0;
          cnt   <= '0;
          an    <= AN_OFF;
          seg7  <= SEG_OFF;
        end
        BLANK: begin
          if (blank_done) begin
            state <= ON;
            cnt   <= '0;
            an    <= ~(4'b0001 << idx);
            seg7  <= lz ? SEG_OFF : hex7(nib);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (on_done) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= idx + 2'd1;
            an         <= AN_OFF;
            seg7       <= SEG_OFF;
            frame_done <= (idx == 2'd3);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 2'd0;
          cnt   <= '0;
          an    <= AN_OFF;
          seg7  <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl.
// Reference model derives outputs from time-in-frame arithmetic.
module tb_seg7_scan_ctrl;

  localparam int DIV = 10;
  localparam int BLK = 2;
  localparam int P   = DIV + BLK;
  localparam int F   = 4 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [6:0]  seg7;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIV(DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .load(load),
    .digits(digits),
    .an(an),
    .seg7(seg7),
    .frame_done(frame_done)
  );

  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  int          t = -1;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pv = 1'b0;

  logic [6:0] dec_t [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic bit lz_blank(input int k, input logic [15:0] d);
    logic [15:0] sh;
    sh = d >> (4 * k);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (k >= 1) && (sh == 16'h0);
`else
    return (sh != sh);
`endif
  endfunction

  task automatic step(input bit r, input bit e, input bit l,
                      input logic [15:0] d);
    logic [3:0]  ea;
    logic [6:0]  es;
    logic [15:0] sh;
    bit          ef;
    bit          cm;
    int          p;
    int          k;
    int          w;
    ea = 4'hF;
    es = 7'h7F;
    ef = 1'b0;
    cm = 1'b0;
    if (r) begin
      t      = -1;
      m_disp = 16'h0;
      m_pend = 16'h0;
      m_pv   = 1'b0;
    end else begin
      if (t < 0) cm = m_pv;
      if (!e) begin
        t = -1;
      end else if (t < 0) begin
        t = 0;
      end else begin
        t++;
        if (t % F == 0) begin
          ef = 1'b1;
          cm = m_pv;
        end
      end
      if (cm) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (l) begin
        m_pend = d;
        m_pv   = 1'b1;
      end
      if (t >= 0) begin
        p = t % F;
        k = p / P;
        w = p % P;
        if (w >= BLK) begin
          ea = ~(4'b0001 << k);
          sh = m_disp >> (4 * k);
          es = lz_blank(k, m_disp) ? 7'h7F : dec_t[sh[3:0]];
        end
      end
    end
    exp_q.push_back({ea, es, ef});
  endtask

  task automatic cyc(input bit r, input bit e, input bit l,
                     input logic [15:0] d);
    rst    = r;
    enable = e;
    load   = l;
    digits = d;
    step(r, e, l, d);
    @(negedge clk);
  endtask

  task automatic run_until(input int phase);
    int n;
    n = 0;
    while (!(t >= 0 && (t % F) == phase) && n < 300) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL run_until phase %0d: reached after %0d cycles, required < 300",
               phase, n);
    end
  endtask

  // Monitor: one expected output word per clock edge.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at cycle %0d: an=%b seg7=%b fd=%b",
                 cycle_no, an, seg7, frame_done);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg7, frame_done} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: an=%b seg7=%b fd=%b, expected an=%b seg7=%b fd=%b",
                   cycle_no, an, seg7, frame_done, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  initial begin
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);

    cyc(1'b0, 1'b0, 1'b1, 16'hA5F0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    run_until(17);
    cyc(1'b0, 1'b1, 1'b1, 16'h1111);
    repeat (2 * F) cyc(1'b0, 1'b1, 1'b0, 16'h0);

    run_until(30);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (F) cyc(1'b0, 1'b1, 1'b0, 16'h0);

    cyc(1'b0, 1'b1, 1'b1, 16'h0040);
    repeat (2 * F + 2) cyc(1'b0, 1'b1, 1'b0, 16'h0);

    run_until(20);
    cyc(1'b0, 1'b1, 1'b1, 16'hBEEF);
    run_until(47);
    cyc(1'b0, 1'b1, 1'b1, 16'hC0DE);
    repeat (2 * F) cyc(1'b0, 1'b1, 1'b0, 16'h0);

    run_until(40);
    cyc(1'b1, 1'b1, 1'b1, 16'h9999);
    repeat (F + 4) cyc(1'b0, 1'b1, 1'b0, 16'h0);

    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 15) != 0,
          $urandom_range(0, 9) == 0,
          16'($urandom));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
